hazard_scheduler: RTL and testbench

Issue-stage scheduler between the instruction decoder and the execute/writeback pipeline.
- Consumes the decoded fields per instruction: rs, rt, rd, register-file write enable, MUL select, LW, branch and jump flags.
- Decides each cycle whether the presented instruction issues or stalls.
- Tracks in-flight register writes in a scoreboard and sequences the multi-cycle multiplier.
- Serialises branches and generates flush pulses for control transfers.

---
 rtl/hazard_scheduler.sv | 133 +++++++++++++
 tb/tb_hazard_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Issue-stage scheduler: scoreboard data hazards, multiplier sequencing, branch serialisation and flush.
// Optional FORWARDING_EN macro: only load-use (slot 0, ld=1) producers hazard non-MUL consumers.
module hazard_scheduler #(
   parameter int PIPE_DEPTH = 3,
   parameter int MUL_LAT    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [4:0] in_rs,
   input  logic [4:0] in_rt,
   input  logic [4:0] in_rd,
   input  logic       in_we_rf,
   input  logic       in_mul,
   input  logic       in_load,
   input  logic       in_branch,
   input  logic       in_jmp,
   input  logic       br_resolved,
   input  logic       br_taken,
   output logic       issue,
   output logic       stall,
   output logic       flush,
   output logic       mul_busy,
   output logic       mul_wb,
   output logic [4:0] mul_wb_rd,
   output logic       wb_en,
   output logic [4:0] wb_rd
);

   localparam int CW = $clog2(MUL_LAT + 1);

   typedef enum logic [1:0] {RUN, WAIT_BR, FLUSH} state_t;

   state_t                        state, state_nxt;
   logic [PIPE_DEPTH-1:0]         sb_v;
   logic [PIPE_DEPTH-1:0][4:0]    sb_rd;
   logic [CW-1:0]                 mul_cnt;
   logic [4:0]                    mul_rd;
   logic                          sb_hit, mul_hit, structural, hazard, issue_c;

   function automatic logic src_match(input logic [4:0] src, input logic [4:0] rd);
      return (src != 5'd0) && (src == rd);
   endfunction

`ifdef FORWARDING_EN
   // Only slot 0's load flag is ever consulted, so older slots do not carry it.
   logic ld0;

   always_comb begin
      sb_hit = sb_v[0] & ld0 & (src_match(in_rs, sb_rd[0]) | src_match(in_rt, sb_rd[0]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ld0 <= 1'b0;
      else     ld0 <= in_load;
   end
`else
   logic unused_load;
   assign unused_load = in_load;

   always_comb begin
      sb_hit = 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++)
         if (sb_v[i] && (src_match(in_rs, sb_rd[i]) || src_match(in_rt, sb_rd[i])))
            sb_hit = 1'b1;
   end
`endif

   assign mul_busy = (mul_cnt != '0);

   // The MUL destination stays hazardous through its writeback cycle (no same-cycle bypass).
   assign mul_hit    = (mul_busy | mul_wb) & (src_match(in_rs, mul_rd) | src_match(in_rt, mul_rd));
   assign structural = (in_mul & mul_busy) |
                       (~in_mul & in_we_rf & (mul_cnt == CW'(PIPE_DEPTH)));
   assign hazard     = sb_hit | mul_hit;

   always_comb begin
      state_nxt = state;
      issue_c   = 1'b0;
      flush     = 1'b0;
      case (state)
         RUN: begin
            issue_c = in_valid & ~hazard & ~structural;
            if (issue_c && in_branch)   state_nxt = WAIT_BR;
            else if (issue_c && in_jmp) state_nxt = FLUSH;
         end
         WAIT_BR: begin
            if (br_resolved) state_nxt = br_taken ? FLUSH : RUN;
         end
         FLUSH: begin
            flush     = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign issue = issue_c & ~rst;
   assign stall = in_valid & ~issue_c & ~rst;
   assign wb_en = sb_v[PIPE_DEPTH-1];
   assign wb_rd = sb_rd[PIPE_DEPTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         sb_v      <= '0;
         sb_rd     <= '0;
         mul_cnt   <= '0;
         mul_rd    <= '0;
         mul_wb    <= 1'b0;
         mul_wb_rd <= '0;
      end else begin
         state <= state_nxt;
         for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
            sb_v[i]  <= sb_v[i-1];
            sb_rd[i] <= sb_rd[i-1];
         end
         sb_v[0]  <= issue_c & in_we_rf & ~in_mul & (in_rd != 5'd0);
         sb_rd[0] <= in_rd;

         // Loaded with MUL_LAT-1 so the count reads MUL_LAT-k in the k-th cycle after issue.
         if (issue_c && in_mul) begin
            mul_cnt <= CW'(MUL_LAT - 1);
            mul_rd  <= in_rd;
         end else if (mul_busy) begin
            mul_cnt <= mul_cnt - CW'(1);
         end
         mul_wb    <= (mul_cnt == CW'(1)) | (issue_c & in_mul & (MUL_LAT == 1));
         mul_wb_rd <= (mul_cnt == CW'(1)) ? mul_rd : in_rd;
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized + directed bench for hazard_scheduler against a cycle-indexed event model.
module tb_hazard_scheduler;
   localparam int PD = 3;
   localparam int ML = 4;

   logic       clk = 1'b0, rst = 1'b1;
   logic       in_valid = 0, in_we_rf = 0, in_mul = 0, in_load = 0, in_branch = 0, in_jmp = 0;
   logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
   logic       br_resolved = 0, br_taken = 0;
   logic       issue, stall, flush, mul_busy, mul_wb, wb_en;
   logic [4:0] mul_wb_rd, wb_rd;

   hazard_scheduler #(.PIPE_DEPTH(PD), .MUL_LAT(ML)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_we_rf(in_we_rf), .in_mul(in_mul), .in_load(in_load), .in_branch(in_branch),
      .in_jmp(in_jmp), .br_resolved(br_resolved), .br_taken(br_taken), .issue(issue),
      .stall(stall), .flush(flush), .mul_busy(mul_busy), .mul_wb(mul_wb),
      .mul_wb_rd(mul_wb_rd), .wb_en(wb_en), .wb_rd(wb_rd)
   );

   always #5 clk = ~clk;

   // Model: each write is remembered by the cycle it issued and the cycle it lands.
   typedef struct {int iss; int wb; logic [4:0] rd; bit ld;} wr_t;
   wr_t        wq[$];
   int         cyc = 0, mul_wbc = -1, flush_c = -1;
   logic [4:0] m_rd = 0;
   bit         br_wait = 0, last_iss = 0;
   int         checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit src_haz(input logic [4:0] s);
      bit h = 0;
      if (s == 5'd0) return 0;
      foreach (wq[i])
         if (wq[i].rd == s && wq[i].wb >= cyc) begin
`ifdef FORWARDING_EN
            if (wq[i].ld && wq[i].iss + 1 == cyc) h = 1;
`else
            h = 1;
`endif
         end
      if (mul_wbc >= cyc && m_rd == s) h = 1;
      return h;
   endfunction

   task automatic step();
      bit haz, strc, can, e_iss, e_wb;
      logic [4:0] e_wbrd;
      #1;
      haz   = src_haz(in_rs) || src_haz(in_rt);
      strc  = (in_mul && mul_wbc > cyc) || (!in_mul && in_we_rf && cyc + PD == mul_wbc);
      can   = !br_wait && flush_c != cyc;
      e_iss = in_valid && can && !haz && !strc;
      e_wb  = 0;
      e_wbrd = 0;
      foreach (wq[i]) if (wq[i].wb == cyc) begin e_wb = 1; e_wbrd = wq[i].rd; end
      chk("issue", 32'(issue), 32'(e_iss));
      chk("stall", 32'(stall), 32'(in_valid && !e_iss));
      chk("flush", 32'(flush), 32'(flush_c == cyc));
      chk("mul_busy", 32'(mul_busy), 32'(mul_wbc > cyc));
      chk("mul_wb", 32'(mul_wb), 32'(mul_wbc == cyc));
      if (mul_wbc == cyc) chk("mul_wb_rd", 32'(mul_wb_rd), 32'(m_rd));
      chk("wb_en", 32'(wb_en), 32'(e_wb));
      if (e_wb) chk("wb_rd", 32'(wb_rd), 32'(e_wbrd));
      if (br_wait && br_resolved) begin
         br_wait = 0;
         if (br_taken) flush_c = cyc + 1;
      end
      if (e_iss) begin
         if (in_mul) begin
            mul_wbc = cyc + ML;
            m_rd    = in_rd;
         end else if (in_we_rf && in_rd != 0) begin
            wq.push_back('{cyc, cyc + PD, in_rd, in_load});
         end
         if (in_branch)   br_wait = 1;
         else if (in_jmp) flush_c = cyc + 1;
      end
      while (wq.size() > 0 && wq[0].wb <= cyc) void'(wq.pop_front());
      last_iss = e_iss;
      cyc++;
   endtask

   task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input bit we, input bit mul, input bit ld, input bit br, input bit jmp);
      in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_we_rf = we;
      in_mul = mul; in_load = ld; in_branch = br; in_jmp = jmp;
   endtask

   // Holds one instruction until the DUT issues it; n = stall cycles (20 on timeout).
   task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input bit we, input bit mul, input bit ld, input bit br, input bit jmp,
                          output int n);
      n = 20;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(1, rs, rt, rd, we, mul, ld, br, jmp);
         br_resolved = 0;
         step();
         if (issue) begin n = k; break; end
      end
   endtask

   task automatic cycle_br(input bit v, input bit res, input bit tkn);
      @(negedge clk);
      drive(v, 5'd1, 5'd2, 5'd10, 1, 0, 0, 0, 0);
      br_resolved = res;
      br_taken    = tkn;
      step();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         br_resolved = 0;
         step();
      end
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      br_resolved = 0;
      rst = 1;
      #1;
      chk("rst_issue", 32'(issue), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_mul_busy", 32'(mul_busy), 32'd0);
      chk("rst_mul_wb", 32'(mul_wb), 32'd0);
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      wq.delete();
      mul_wbc = -1; flush_c = -1; br_wait = 0; last_iss = 0;
   endtask

   initial begin
      int n, k;
      do_reset();
      idle(2);

      present(1, 2, 3, 1, 0, 0, 0, 0, n);  chk("add_first", 32'(n), 32'd0);
`ifdef FORWARDING_EN
      present(3, 1, 4, 1, 0, 0, 0, 0, n);  chk("add_dep_stalls", 32'(n), 32'd0);
`else
      present(3, 1, 4, 1, 0, 0, 0, 0, n);  chk("add_dep_stalls", 32'(n), 32'(PD));
`endif
      idle(PD + 1);
      present(1, 0, 5, 1, 0, 1, 0, 0, n);
`ifdef FORWARDING_EN
      present(5, 2, 6, 1, 0, 0, 0, 0, n);  chk("load_use_stalls", 32'(n), 32'd1);
`else
      present(5, 2, 6, 1, 0, 0, 0, 0, n);  chk("load_use_stalls", 32'(n), 32'(PD));
`endif
      idle(PD + 1);
      present(1, 2, 0, 1, 0, 0, 0, 0, n);
      present(0, 0, 11, 1, 0, 0, 0, 0, n); chk("r0_no_hazard", 32'(n), 32'd0);
      idle(ML + 1);
      present(1, 2, 7, 1, 1, 0, 0, 0, n);
      present(3, 4, 8, 1, 1, 0, 0, 0, n);  chk("mul_mul_stalls", 32'(n), 32'(ML - 1));
      idle(ML + 1);
      present(1, 2, 7, 1, 1, 0, 0, 0, n);
      present(1, 2, 9, 1, 0, 0, 0, 0, n);  chk("mul_wb_collision", 32'(n), 32'd1);
      idle(ML + 1);
      present(1, 2, 0, 0, 0, 0, 1, 0, n);  chk("bne_issue", 32'(n), 32'd0);
      cycle_br(1, 0, 0); cycle_br(1, 0, 0); cycle_br(1, 1, 1); cycle_br(1, 0, 0); cycle_br(1, 0, 0);
      present(1, 2, 0, 0, 0, 0, 1, 0, n);
      cycle_br(1, 0, 0); cycle_br(1, 1, 0); cycle_br(1, 0, 0); cycle_br(1, 1, 1);
      idle(PD + 1);
      present(0, 0, 0, 0, 0, 0, 0, 1, n);  chk("jmp_issue", 32'(n), 32'd0);
      idle(2);
      present(1, 2, 7, 1, 1, 0, 0, 0, n);
      present(1, 2, 12, 1, 0, 0, 0, 0, n);
      idle(1);
      do_reset();
      idle(ML + 2);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!(in_valid && !last_iss && $urandom_range(9) != 0)) begin
            k = $urandom_range(9);
            drive($urandom_range(4) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
                  5'($urandom_range(7)),
                  (k < 3) || (k > 4 && $urandom_range(9) != 0),
                  k < 2, k == 2, k == 3, k == 4);
         end
         br_resolved = br_wait ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
         br_taken    = 1'($urandom_range(1));
         step();
         if ($urandom_range(599) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
